temp_sampler: RTL and testbench

Upstream neighbour of the threshold monitor. Accepts signed binary temperature samples in tenths of a degree (e.g. 425 = 42.5). Converts each magnitude to 3-digit BCD (huns.tens.ones = XX.X) with a sequential shift-add-3 converter. Holds the current and previous converted sample, and issues a one-cycle enable strobe that drives the monitor's en input.

---
 rtl/temp_sampler_pkg.sv | 20 ++
 rtl/temp_sampler_bin_to_bcd_step.sv | 40 ++++
 rtl/temp_sampler.sv | 164 ++++++++++++++++
 tb/tb_temp_sampler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/temp_sampler_pkg.sv
// -----------------------------------------------------------------------------
// temp_sampler_pkg
// Shared constants for the temperature sampler: FSM state encodings,
// the magnitude saturation limit and the width of the BCD field.
// -----------------------------------------------------------------------------
package temp_sampler_pkg;

   typedef enum logic [1:0] {
      TS_IDLE   = 2'd0,
      TS_CONV   = 2'd1,
      TS_COMMIT = 2'd2
   } ts_state_t;

   // Largest magnitude that can be shown as XX.X (99.9 degrees).
   localparam int TS_MAX_MAG = 999;

   // Three BCD digits: hundreds, tens, ones.
   localparam int BCD_W = 12;

endpackage : temp_sampler_pkg

// File: rtl/temp_sampler_bin_to_bcd_step.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_step
// One combinational iteration of the shift-add-3 (double dabble) converter.
// The working register is {huns, tens, ones, binary}. Every BCD nibble that
// is 5 or more gets 3 added, then the whole register shifts left by one.
//
// Ports:
//   din   in   BCD_W+BIN_W  working register before this iteration
//   dout  out  BCD_W+BIN_W  working register after this iteration
// -----------------------------------------------------------------------------
module bin_to_bcd_step
   import temp_sampler_pkg::*;
#(
   parameter int BIN_W = 10
) (
   input  logic [BCD_W+BIN_W-1:0] din,
   output logic [BCD_W+BIN_W-1:0] dout
);

   logic [BCD_W-1:0] bcd_adj;
   logic [3:0]       nib;

   // NOTE: every variable written here gets a default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      bcd_adj = din[BCD_W+BIN_W-1 -: BCD_W];
      nib     = '0;
      for (int i = 0; i < BCD_W / 4; i++) begin
         nib = din[BIN_W + 4*i +: 4];
         if (nib >= 4'd5) begin
            bcd_adj[4*i +: 4] = nib + 4'd3;
         end
      end
   end

   // The top bit of the hundreds nibble can never be set for inputs <= 999,
   // so dropping it on the shift loses nothing.
   assign dout = {bcd_adj[BCD_W-2:0], din[BIN_W-1:0], 1'b0};

endmodule : bin_to_bcd_step

// File: rtl/temp_sampler.sv
// -----------------------------------------------------------------------------
// temp_sampler
// Accepts signed temperature samples in tenths of a degree, saturates the
// magnitude to 99.9, converts it to three BCD digits with a sequential
// shift-add-3 converter (one iteration per clock), and keeps the current and
// previous converted samples. out_en pulses for one cycle after each update
// and drives the en input of the threshold monitor downstream.
//
// Ports:
//   clk        in   1     system clock
//   rst        in   1     synchronous, active-high reset
//   in_valid   in   1     sample present on in_temp
//   in_temp    in   IN_W  signed sample, tenths of a degree
//   in_ready   out  1     high only in IDLE; accept = in_valid & in_ready
//   cur_*      out  4/1   current sample digits and sign (1 = negative)
//   old_*      out  4/1   previous sample digits and sign
//   out_en     out  1     one-cycle strobe: cur/old just updated
//   overrange  out  1     current sample magnitude was saturated
//   busy       out  1     conversion in progress
// -----------------------------------------------------------------------------
module temp_sampler
   import temp_sampler_pkg::*;
#(
   parameter int IN_W    = 11,
   parameter int MAG_W   = 10,
   parameter int MAX_MAG = TS_MAX_MAG
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [IN_W-1:0] in_temp,
   output logic            in_ready,
   output logic [3:0]      cur_ones,
   output logic [3:0]      cur_tens,
   output logic [3:0]      cur_huns,
   output logic            cur_sign,
   output logic [3:0]      old_ones,
   output logic [3:0]      old_tens,
   output logic [3:0]      old_huns,
   output logic            old_sign,
   output logic            out_en,
   output logic            overrange,
   output logic            busy
);

   localparam int SR_W  = BCD_W + MAG_W;
   localparam int CNT_W = $clog2(MAG_W + 1);

   localparam logic [IN_W-1:0]  MAX_IN   = IN_W'(MAX_MAG);
   localparam logic [MAG_W-1:0] MAX_BIN  = MAG_W'(MAX_MAG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);

   ts_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [SR_W-1:0]  sr_q, sr_step;
   logic             sign_pend_q;
   logic             ovr_pend_q;
   logic             first_q;

   // Input magnitude and saturation. The most negative input negates to
   // itself as an unsigned value (1024), which is above the limit and so
   // saturates like any other out-of-range sample.
   logic [IN_W-1:0]  abs_val;
   logic             over_lim;
   logic [MAG_W-1:0] sat_mag;

   assign abs_val  = in_temp[IN_W-1] ? -in_temp : in_temp;
   assign over_lim = abs_val > MAX_IN;
   assign sat_mag  = over_lim ? MAX_BIN : abs_val[MAG_W-1:0];

   bin_to_bcd_step #(
      .BIN_W (MAG_W)
   ) u_step (
      .din  (sr_q),
      .dout (sr_step)
   );

   // ---------------------------------------------------------------- FSM
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TS_IDLE:   if (in_valid)            state_d = TS_CONV;
         TS_CONV:   if (cnt_q == CNT_LAST)   state_d = TS_COMMIT;
         TS_COMMIT:                          state_d = TS_IDLE;
         default:                            state_d = TS_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == TS_IDLE);
      busy     = (state_q != TS_IDLE);
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         sr_q        <= '0;
         sign_pend_q <= 1'b0;
         ovr_pend_q  <= 1'b0;
         first_q     <= 1'b1;
         cur_huns    <= '0;
         cur_tens    <= '0;
         cur_ones    <= '0;
         cur_sign    <= 1'b0;
         old_huns    <= '0;
         old_tens    <= '0;
         old_ones    <= '0;
         old_sign    <= 1'b0;
         out_en      <= 1'b0;
         overrange   <= 1'b0;
      end else begin
         out_en <= 1'b0;
         case (state_q)
            TS_IDLE: begin
               if (in_valid) begin
                  sign_pend_q <= in_temp[IN_W-1];
                  ovr_pend_q  <= over_lim;
                  sr_q        <= {{BCD_W{1'b0}}, sat_mag};
                  cnt_q       <= '0;
               end
            end
            TS_CONV: begin
               sr_q  <= sr_step;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            TS_COMMIT: begin
               // The very first sample after reset is copied into old as well,
               // so the first delta seen downstream is zero.
               if (first_q) begin
                  old_huns <= sr_q[SR_W-1 -: 4];
                  old_tens <= sr_q[SR_W-5 -: 4];
                  old_ones <= sr_q[SR_W-9 -: 4];
                  old_sign <= sign_pend_q;
               end else begin
                  old_huns <= cur_huns;
                  old_tens <= cur_tens;
                  old_ones <= cur_ones;
                  old_sign <= cur_sign;
               end
               cur_huns  <= sr_q[SR_W-1 -: 4];
               cur_tens  <= sr_q[SR_W-5 -: 4];
               cur_ones  <= sr_q[SR_W-9 -: 4];
               cur_sign  <= sign_pend_q;
               overrange <= ovr_pend_q;
               out_en    <= 1'b1;
               first_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule : temp_sampler

// File: tb/tb_temp_sampler.sv
// -----------------------------------------------------------------------------
// tb_temp_sampler
// Scoreboard bench for temp_sampler. The negedge monitor predicts each accept
// from its own notion of when the sampler is idle, computes the expected
// digits with plain decimal arithmetic, queues them with the cycle at which
// out_en is due, and compares every output on every cycle.
// -----------------------------------------------------------------------------
module tb_temp_sampler;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [10:0] in_temp;
   logic        in_ready;
   logic [3:0]  cur_ones, cur_tens, cur_huns;
   logic        cur_sign;
   logic [3:0]  old_ones, old_tens, old_huns;
   logic        old_sign;
   logic        out_en;
   logic        overrange;
   logic        busy;

   temp_sampler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_temp   (in_temp),
      .in_ready  (in_ready),
      .cur_ones  (cur_ones),
      .cur_tens  (cur_tens),
      .cur_huns  (cur_huns),
      .cur_sign  (cur_sign),
      .old_ones  (old_ones),
      .old_tens  (old_tens),
      .old_huns  (old_huns),
      .old_sign  (old_sign),
      .out_en    (out_en),
      .overrange (overrange),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [3:0] ch, ct, co;
      logic       cs;
      logic [3:0] oh, ot, oo;
      logic       os;
      logic       ovr;
   } exp_t;

   exp_t q[$];
   exp_t vis;          // what the outputs should currently show
   int   cyc      = 0;
   int   ready_at = 0;
   bit   chk_en   = 1'b0;
   bit   first    = 1'b1;
   logic [3:0] m_h, m_t, m_o;
   logic       m_s;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Edge bookkeeping: a reset edge discards any in-flight expectation.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         vis      = '{default: '0};
         first    = 1'b1;
         ready_at = cyc;
         chk_en   = 1'b1;
      end
   end

   // Monitor and reference model.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         bit   en_exp;
         bit   rdy_exp;
         en_exp = (q.size() > 0) && (q[0].due == cyc);
         check("out_en", 32'(out_en), 32'(en_exp));
         if (en_exp) vis = q.pop_front();
         rdy_exp = (cyc >= ready_at);
         check("in_ready", 32'(in_ready), 32'(rdy_exp));
         check("busy", 32'(busy), 32'(!rdy_exp));
         check("cur", {19'd0, cur_huns, cur_tens, cur_ones, cur_sign},
               {19'd0, vis.ch, vis.ct, vis.co, vis.cs});
         check("old", {19'd0, old_huns, old_tens, old_ones, old_sign},
               {19'd0, vis.oh, vis.ot, vis.oo, vis.os});
         check("overrange", 32'(overrange), 32'(vis.ovr));

         if (!rst && in_valid && rdy_exp) begin
            int s, mag;
            s   = int'($signed(in_temp));
            mag = (s < 0) ? -s : s;
            e.ovr = (mag > 999);
            if (mag > 999) mag = 999;
            e.ch = 4'(mag / 100);
            e.ct = 4'((mag / 10) % 10);
            e.co = 4'(mag % 10);
            e.cs = (s < 0);
            if (first) begin
               {e.oh, e.ot, e.oo, e.os} = {e.ch, e.ct, e.co, e.cs};
            end else begin
               {e.oh, e.ot, e.oo, e.os} = {m_h, m_t, m_o, m_s};
            end
            {m_h, m_t, m_o, m_s} = {e.ch, e.ct, e.co, e.cs};
            first    = 1'b0;
            e.due    = cyc + 12;  // accept at edge cyc+1, commit at cyc+12
            ready_at = cyc + 12;
            q.push_back(e);
         end
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic send(input int v);
      int n = 0;
      in_valid = 1'b1;
      in_temp  = v[10:0];
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready never rose for sample %0d", v);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() > 0 || cyc < ready_at) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: %0d results still outstanding", q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_temp  = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // First sample, then negative, then saturation cases.
      send(425);   wait_idle();
      send(-37);   wait_idle();
      send(1023);  wait_idle();
      send(-1024); wait_idle();
      send(999);   wait_idle();
      send(0);     wait_idle();
      send(-999);  wait_idle();
      send(1000);  wait_idle();

      // Second sample held during conversion must wait for IDLE.
      send(100);
      send(200);
      wait_idle();

      // Reset in the middle of a conversion (edge E5 after accept E0).
      send(425);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(50);    wait_idle();

      // Randomized samples, some back-to-back, some with idle gaps.
      for (int i = 0; i < 60; i++) begin
         int gap;
         gap = int'($urandom_range(3));
         repeat (gap) begin
            @(posedge clk); #1;
         end
         send(int'($urandom_range(2047)));
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_temp_sampler
